// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V decode constants for the immediate generator.
//   - 7-bit major opcode constants (instr[6:0])
//   - imm_fmt_e: 3-bit immediate format tag carried on out_fmt
// No ports; imported by imm_decode and imm_gen_pipe.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_SH   = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational RISC-V immediate extraction.
//   instr   [31:0]   raw instruction word
//   imm     [XLEN-1:0] extracted immediate (sign/zero extended)
//   fmt     imm_fmt_e  which immediate format was recognised
//   illegal           opcode not recognised by this decoder
// Optional macro IMM_GEN_CSR_EN: decode CSR*I zimm (fmt Z). Without it,
// every SYSTEM opcode yields imm=0, fmt NONE and is not flagged illegal.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        imm = sext32({{20{instr[31]}}, instr[31:20]});
        fmt = FMT_I;
      end
      OP_OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift amount width follows XLEN: bit 25 is part of shamt only on RV64.
          if (XLEN == 64) imm = zext32({26'd0, instr[25:20]});
          else            imm = zext32({27'd0, instr[24:20]});
          fmt = FMT_SH;
        end else begin
          imm = sext32({{20{instr[31]}}, instr[31:20]});
          fmt = FMT_I;
        end
      end
      OP_STORE: begin
        imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
        fmt = FMT_S;
      end
      OP_BRANCH: begin
        imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0});
        fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm = sext32({instr[31:12], 12'd0});
        fmt = FMT_U;
      end
      OP_JAL: begin
        imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0});
        fmt = FMT_J;
      end
      OP_OP, OP_MISC_MEM: begin
        // No immediate; legal.
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        if (funct3[2]) begin
          imm = zext32({27'd0, instr[19:15]});
          fmt = FMT_Z;
        end
`endif
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry skid buffer.
//   clk, reset (sync, active high), flush (sync discard of buffered entries)
//   in_valid/in_ready/in_instr[31:0]/in_tag[TAG_W-1:0]   upstream
//   out_valid/out_ready/out_imm[XLEN-1:0]/out_fmt[2:0]/
//   out_illegal/out_tag[TAG_W-1:0]                          downstream
// Optional macro IMM_GEN_CSR_EN (passed to imm_decode): CSR*I zimm decode.
//
// Handshake: a beat moves on a side when valid && ready at the rising clk
// edge. Once out_valid is high, out_* hold until out_ready takes the beat.
// in_ready depends only on registered state (skid empty) and reset, so
// there is no combinational path from out_ready to in_ready.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_illegal;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  logic             accept;
  logic             out_free;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_ready = !skid_valid && !reset;
  assign accept   = in_valid && in_ready;
  // Output register can take a new entry when empty or being drained.
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_fmt      <= '0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= '0;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else if (flush) begin
      // Discards everything, including an entry accepted this same cycle.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        // in_ready is low while skid is full, so no accept can collide here.
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_fmt     <= skid_fmt;
        out_illegal <= skid_illegal;
        out_tag     <= skid_tag;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= dec_imm;
        out_fmt     <= dec_fmt;
        out_illegal <= dec_illegal;
        out_tag     <= in_tag;
      end else begin
        out_valid   <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled and full: park the new entry in the skid register.
      skid_valid   <= 1'b1;
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_illegal <= dec_illegal;
      skid_tag     <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe. Two instances share the
// stimulus: XLEN=32 (main, handshake checked) and XLEN=64 (decode widths).
// A tag scoreboard follows every accepted beat through to the output.
module tb_imm_gen_pipe;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [31:0] out_tag;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic        out_illegal64;
  logic [31:0] out_tag64;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  bit stress = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Samples 1 time unit before each rising edge; inputs change on falling edges.
  always begin
    logic [31:0] t;
    @(negedge clk);
    #4;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", 64'(out_tag), 64'hDEAD);
        end else begin
          t = exp_q.pop_front();
          check("sb_tag", 64'(out_tag), 64'(t));
          if (stress)
            check("sb_imm", 64'(out_imm), 64'({{20{t[11]}}, t[11:0]}));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_tag);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic dec(input string name, input logic [31:0] instr,
                     input logic [63:0] e32, input logic [63:0] e64,
                     input logic [2:0] efmt, input logic eill);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_tag    = instr;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_imm32"}, 64'(out_imm), e32);
    check({name, "_imm64"}, out_imm64, e64);
    check({name, "_fmt"}, 64'(out_fmt), 64'(efmt));
    check({name, "_fmt64"}, 64'(out_fmt64), 64'(efmt));
    check({name, "_ill"}, 64'(out_illegal), 64'(eill));
    @(negedge clk);
  endtask

  localparam logic [31:0] ADDI_M1 = 32'hFFF00093;

  initial begin
    logic [31:0] cnt;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_fmt", 64'(out_fmt), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // ---- decode vectors ----
    dec("addi_m1", ADDI_M1, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
    dec("beq_m4", 32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0);
    dec("jal_8", 32'h008000EF, 64'h8, 64'h8, FMT_J, 1'b0);
    dec("lui", 32'h123450B7, 64'h12345000, 64'h12345000, FMT_U, 1'b0);
    dec("lui_neg", 32'h800002B7, 64'h80000000, 64'hFFFFFFFF80000000, FMT_U, 1'b0);
    dec("srai_2", 32'h4020D093, 64'h2, 64'h2, FMT_SH, 1'b0);
    dec("slli_63", 32'h03F09093, 64'd31, 64'd63, FMT_SH, 1'b0);
    dec("sw_m4", 32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_S, 1'b0);
    dec("add", 32'h002081B3, 64'h0, 64'h0, FMT_NONE, 1'b0);
    dec("fence", 32'h0FF0000F, 64'h0, 64'h0, FMT_NONE, 1'b0);
    dec("ill_7f", 32'h0000007F, 64'h0, 64'h0, FMT_NONE, 1'b1);
    dec("ill_rvc", 32'h00000001, 64'h0, 64'h0, FMT_NONE, 1'b1);
    dec("csrrw", 32'h30529073, 64'h0, 64'h0, FMT_NONE, 1'b0);
`ifdef IMM_GEN_CSR_EN
    dec("csrrwi", 32'h0002D073, 64'h5, 64'h5, FMT_Z, 1'b0);
`else
    dec("csrrwi", 32'h0002D073, 64'h0, 64'h0, FMT_NONE, 1'b0);
`endif

    // ---- backpressure: tags 1,2,3 with output stalled ----
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI_M1; in_tag = 32'd1;
    @(negedge clk);
    check("bp_rdy_after1", 64'(in_ready), 64'd1);
    check("bp_tag1", 64'(out_tag), 64'd1);
    in_tag = 32'd2;
    @(negedge clk);
    check("bp_rdy_full", 64'(in_ready), 64'd0);
    in_tag = 32'd3;
    @(negedge clk);
    check("bp_rdy_still_full", 64'(in_ready), 64'd0);
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_tag", 64'(out_tag), 64'd1);
    check("bp_hold_imm", 64'(out_imm), 64'hFFFFFFFF);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out2", 64'(out_tag), 64'd2);
    check("bp_rdy_free", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("bp_out3", 64'(out_tag), 64'd3);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'd0);

    // ---- flush with both entries full and input offered ----
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd10;
    @(negedge clk);
    in_tag = 32'd11;
    @(negedge clk);
    check("fl_full", 64'(in_ready), 64'd0);
    in_tag = 32'd12; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("fl_no_emit", 64'(out_valid), 64'd0);

    // ---- reset mid-transfer ----
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd20;
    @(negedge clk);
    in_tag = 32'd21;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    check("mrst_in_ready_after", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("mrst_no_emit", 64'(out_valid), 64'd0);

    // ---- random valid/ready, order and data via scoreboard ----
    stress = 1'b1;
    cnt = 32'h100;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_tag    = cnt;
      in_instr  = {cnt[11:0], 5'd2, 3'b000, 5'd1, 7'b0010011};
      cnt       = cnt + 32'd37;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("sb_drain_empty", 64'(exp_q.size()), 64'd0);
    check("sb_final_out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning immediate output width (legal: 32, 64).
REQ-002 SHALL have parameter TAG_W, default 32, meaning width of the sideband tag (e.g. PC) carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_tag input TAG_W for the upstream handshake.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_imm output XLEN, out_fmt output 3, out_illegal output 1, out_tag output TAG_W for the downstream handshake.

Function
REQ-008 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready, both at the clk edge.
REQ-009 SHALL present a transferred entry on out_* exactly 1 cycle after acceptance when the output register is empty or draining.
REQ-010 SHALL buffer entries in a 2-entry skid (output register + skid register); in_ready = !skid_valid && !reset, a registered-state function with no combinational path from out_ready.
REQ-011 SHALL, on input accept while output stalled and output register full, load the skid register; on the next output transfer, move skid to output.
REQ-012 SHALL preserve strict FIFO order; no entry dropped or duplicated under any valid/ready pattern.
REQ-013 SHALL hold out_* stable while out_valid && !out_ready.
REQ-014 SHALL decode by opcode in_instr[6:0]: 0000011, 1100111, 0010011 (funct3 not 001/101) -> I: sign-extended in[31:20], fmt=1.
REQ-015 SHALL, for opcode 0010011 with funct3 001/101, output zero-extended shamt: in[24:20] when XLEN=32, in[25:20] when XLEN=64; fmt=2.
REQ-016 SHALL, for 0100011 -> S: sign-extended {in[31:25],in[11:7]}, fmt=3.
REQ-017 SHALL, for 1100011 -> B: sign-extended {in[31],in[7],in[30:25],in[11:8],0}, fmt=4.
REQ-018 SHALL, for 0110111/0010111 -> U: {in[31:12],12'b0} sign-extended to XLEN, fmt=5.
REQ-019 SHALL, for 1101111 -> J: sign-extended {in[31],in[19:12],in[20],in[30:21],0}, fmt=6.
REQ-020 SHALL, for 0110011 (R-type) and 0001111 (FENCE), output imm=0, fmt=0, out_illegal=0.
REQ-021 SHALL, for any other opcode (incl. in[1:0]!=11), output imm=0, fmt=0, out_illegal=1; the entry still flows through the handshake.
REQ-022 SHALL, on flush, clear both valid bits next edge; flush overrides a same-cycle input accept (accepted entry discarded) and output transfer status is irrelevant.

Reset
REQ-023 SHALL, while reset is high at a clk edge, clear output and skid valids; out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, in_ready=0.
REQ-024 SHALL assert in_ready=1 in the first cycle after reset deasserts; reset mid-transfer discards all buffered entries.

Configuration
REQ-025 SHALL, with macro IMM_GEN_CSR_EN defined, decode opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) as zero-extended zimm in[19:15], fmt=7.
REQ-026 SHALL, without IMM_GEN_CSR_EN, treat opcode 1110011 (all funct3) as imm=0, fmt=0, out_illegal=0; fmt=7 is never produced.

Structure
REQ-027 SHALL place opcode constants and the 3-bit format enum (NONE=0, I=1, SH=2, S=3, B=4, U=5, J=6, Z=7) in shared package riscv_pkg.
REQ-028 SHALL isolate the pure combinational decode in sub-module imm_decode (instr in; imm, fmt, illegal out), instantiated once before the skid buffer.

Verification
REQ-029 SHALL cover: in 0xFFF00093, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0.
REQ-030 SHALL cover: 0xFE000EE3 -> out_imm=0xFFFFFFFC, fmt=4; 0x008000EF -> 0x00000008, fmt=6; 0x123450B7 -> 0x12345000, fmt=5.
REQ-031 SHALL cover: 0x4020D093 (srai) -> out_imm=2, fmt=2 for XLEN=32 and XLEN=64; XLEN=64 with 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
REQ-032 SHALL cover: out_ready=0, 3 back-to-back inputs tags 1,2,3 -> tags 1,2 accepted, in_ready=0 after the second; release -> outputs tags 1,2,3 in order.
REQ-033 SHALL cover: flush asserted with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emitted.
REQ-034 SHALL cover: 0x0000007F -> illegal=1, imm=0; 0x0002D073 -> fmt=7, imm=5 with IMM_GEN_CSR_EN, fmt=0, imm=0 without.
